// File: rtl/mmu_axi_burst_bridge.sv
// CPU-to-AXI4 bridge: translates kseg0/kseg1/mapped addresses and runs one INCR burst per request.
// Define MMU_BRIDGE_ERR_EN to add cpu_err (sticky bresp/rresp error flag, valid with cpu_done).
module mmu_axi_burst_bridge #(
  parameter int   ADDR_W = 32,
  parameter int   DATA_W = 32,
  parameter int   LEN_W  = 8,
  parameter logic AXI_ID = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_wr,
  input  logic [2:0]          cpu_req_size,
  input  logic [LEN_W-1:0]    cpu_req_len,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  input  logic                cpu_wvalid,
  output logic                cpu_wready,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  output logic                cpu_rlast,
  input  logic                cpu_rready,
  output logic                cpu_done,
`ifdef MMU_BRIDGE_ERR_EN
  output logic                cpu_err,
`endif
  output logic                m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [LEN_W-1:0]    m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [3:0]          m_awcache,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [3:0]          m_arcache,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic                m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, xl_addr;
  logic [3:0]          cache_q, cache_d, xl_cache;
  logic [LEN_W-1:0]    len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]          size_q, size_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                accept, w_open, aw_hs, w_hs, w_last_hs, r_hs, r_last_hs, b_hs;

  assign accept    = cpu_req_valid & (state_q == IDLE);
  assign w_open    = (state_q == WR_DATA) & ~w_done_q;
  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;
  assign w_last_hs = w_hs & m_wlast;
  assign r_hs      = (state_q == RD_DATA) & m_rvalid & cpu_rready;
  assign r_last_hs = r_hs & m_rlast;
  assign b_hs      = (state_q == WR_RESP) & m_bvalid;

  assign cpu_req_ready = (state_q == IDLE);
  assign m_arvalid     = (state_q == RD_ADDR);
  assign m_awvalid     = (state_q == WR_DATA) & ~aw_done_q;
  assign m_wvalid      = cpu_wvalid & w_open;
  assign cpu_wready    = m_wready & w_open;
  assign m_wlast       = w_open & (beat_cnt_q == len_q);
  assign m_wdata       = cpu_wdata;
  assign m_wstrb       = cpu_wstrb;
  assign m_bready      = (state_q == WR_RESP);
  assign m_rready      = (state_q == RD_DATA) & cpu_rready;
  assign cpu_rvalid    = (state_q == RD_DATA) & m_rvalid;
  assign cpu_rlast     = (state_q == RD_DATA) & m_rlast;
  assign cpu_rdata     = m_rdata;
  assign cpu_done      = r_last_hs | b_hs;

  assign m_awid = AXI_ID;  assign m_arid = AXI_ID;
  assign m_awaddr = addr_q; assign m_araddr = addr_q;
  assign m_awlen = len_q;   assign m_arlen = len_q;
  assign m_awsize = size_q; assign m_arsize = size_q;
  assign m_awburst = 2'b01; assign m_arburst = 2'b01;
  assign m_awcache = cache_q; assign m_arcache = cache_q;

  // kseg0 strips the top bit (cached), kseg1 strips three bits (uncached)
  always_comb begin
    xl_addr  = cpu_req_addr;
    xl_cache = 4'b1111;
    case (cpu_req_addr[31:29])
      3'b100:  xl_addr[31] = 1'b0;
      3'b101:  begin xl_addr[31:29] = 3'b000; xl_cache = 4'b0000; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cache_d    = cache_q;
    len_d      = len_q;
    size_d     = size_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = xl_addr;
        cache_d = xl_cache;
        len_d   = cpu_req_len;
        size_d  = cpu_req_size;
        state_d = cpu_req_wr ? WR_DATA : RD_ADDR;
      end
      RD_ADDR: if (m_arready) state_d = RD_DATA;
      RD_DATA: if (r_last_hs) state_d = IDLE;
      WR_DATA: begin
        if (aw_hs) aw_done_d = 1'b1;
        // the counter parks on len after the final beat so it never wraps
        if (w_hs & ~m_wlast) beat_cnt_d = beat_cnt_q + 1'b1;
        if (w_last_hs) w_done_d = 1'b1;
        if ((aw_done_q | aw_hs) & (w_done_q | w_last_hs)) begin
          state_d    = WR_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          beat_cnt_d = '0;
        end
      end
      WR_RESP: if (m_bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cache_q    <= '0;
      len_q      <= '0;
      size_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cache_q    <= cache_d;
      len_q      <= len_d;
      size_q     <= size_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef MMU_BRIDGE_ERR_EN
  logic err_q, err_d, err_now;
  assign err_now = (r_hs & (m_rresp != 2'b00)) | (b_hs & (m_bresp != 2'b00));
  assign err_d   = accept ? 1'b0 : (err_q | err_now);
  assign cpu_err = err_q | err_now;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  logic unused_ok;
  assign unused_ok = ^{m_bid, m_rid};
`else
  logic unused_ok;
  assign unused_ok = ^{m_bid, m_rid, m_rresp, m_bresp};
`endif
endmodule

// File: tb/tb_mmu_axi_burst_bridge.sv
// Randomised bench for mmu_axi_burst_bridge: a cycle-stepped AXI slave/CPU driver plus a
// segment-range address model; builds with or without MMU_BRIDGE_ERR_EN.
module tb_mmu_axi_burst_bridge;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;

  logic cpu_req_valid, cpu_req_ready, cpu_req_wr, cpu_wvalid, cpu_wready, cpu_rvalid, cpu_rlast, cpu_rready, cpu_done;
  logic [2:0] cpu_req_size; logic [7:0] cpu_req_len; logic [31:0] cpu_req_addr, cpu_wdata, cpu_rdata; logic [3:0] cpu_wstrb;
  logic m_awid, m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bid, m_bvalid, m_bready;
  logic m_arid, m_arvalid, m_arready, m_rid, m_rlast, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata; logic [7:0] m_awlen, m_arlen; logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp; logic [3:0] m_awcache, m_arcache, m_wstrb;
`ifdef MMU_BRIDGE_ERR_EN
  logic cpu_err;
`endif

  mmu_axi_burst_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_wr(cpu_req_wr),
    .cpu_req_size(cpu_req_size), .cpu_req_len(cpu_req_len), .cpu_req_addr(cpu_req_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_wvalid(cpu_wvalid), .cpu_wready(cpu_wready),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_rlast(cpu_rlast), .cpu_rready(cpu_rready),
    .cpu_done(cpu_done),
`ifdef MMU_BRIDGE_ERR_EN
    .cpu_err(cpu_err),
`endif
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awcache(m_awcache), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arcache(m_arcache), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0, errors = 0;
  logic [31:0] dq[257];
  logic [31:0] cap_addr; logic [3:0] cap_cache; logic [7:0] cap_len; logic [2:0] cap_size; logic [1:0] cap_burst;
  int lat, n_beats, done_cnt, done_bad, wlast_bad, data_bad, mirror_bad, timeout, err_at_done, rdy_next;
  int acc_cyc, w_lead, same_cyc, cache_bad;
  int stall_pct = 0, addr_delay = 0, err_beat = -1;
  logic [1:0] bresp_val = 2'b00;

  // Segment model: 0x8000_0000..0x9FFF_FFFF and 0xA000_0000..0xBFFF_FFFF map down to physical 0
  function automatic logic [31:0] ref_addr(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
    if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
    return a;
  endfunction
  function automatic logic [3:0] ref_cache(input logic [31:0] a);
    return (a >= 32'hA000_0000 && a < 32'hC000_0000) ? 4'h0 : 4'hF;
  endfunction
  function automatic bit go(input int pct);
    return $urandom_range(99) >= pct;
  endfunction

  task automatic idle_inputs();
    cpu_req_valid = 0; cpu_req_wr = 0; cpu_req_size = 0; cpu_req_len = 0; cpu_req_addr = 0;
    cpu_wdata = 0; cpu_wstrb = 0; cpu_wvalid = 0; cpu_rready = 0;
    m_awready = 0; m_wready = 0; m_bid = 0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
  endtask

  // Drives one whole request cycle by cycle; entered and left at posedge+1.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    int cyc, acc, xin, xout, avc, aw_cyc, wl_cyc; bit a_done, fin, a_hs_now, last_now, exp_done, exp_rr, exp_br, ardy;
    for (int i = 0; i <= 256; i++) dq[i] = $urandom;
    cyc = 0; acc = -1; xin = 0; xout = 0; avc = 0; a_done = 0; fin = 0; aw_cyc = -1; wl_cyc = -2;
    lat = -1; n_beats = 0; done_cnt = 0; done_bad = 0; wlast_bad = 0; data_bad = 0; mirror_bad = 0;
    timeout = 0; err_at_done = 0; w_lead = 0; cache_bad = 0; acc_cyc = -1;
    while (!fin) begin
      if (cyc > 3000) begin timeout = 1; break; end
      cpu_req_valid = (acc < 0); cpu_req_wr = wr; cpu_req_addr = addr; cpu_req_len = len; cpu_req_size = size;
      ardy = (avc >= addr_delay) && go(stall_pct);
      m_awready = wr & ardy; m_arready = !wr & ardy;
      cpu_wvalid = wr && (xin <= int'(len)) && go(stall_pct); cpu_wdata = dq[xin]; cpu_wstrb = 4'hF;
      m_wready = go(stall_pct);
      m_rvalid = !wr && a_done && (xout <= int'(len)) && go(stall_pct);
      m_rdata = dq[xout]; m_rlast = (xout == int'(len)); m_rresp = (xout == err_beat) ? 2'b10 : 2'b00;
      cpu_rready = go(stall_pct);
      m_bvalid = wr && a_done && (xin > int'(len)) && go(stall_pct); m_bresp = bresp_val;
      #1;
      a_hs_now = 0; last_now = 0;
      if (acc < 0 && cpu_req_ready) begin acc = cyc; acc_cyc = cyc; end
      else if (acc >= 0 && !a_done && (wr ? m_awvalid : m_arvalid)) begin
        if (lat < 0) begin
          lat = cyc - acc;
          cap_addr = wr ? m_awaddr : m_araddr; cap_cache = wr ? m_awcache : m_arcache;
          cap_len = wr ? m_awlen : m_arlen; cap_size = wr ? m_awsize : m_arsize; cap_burst = wr ? m_awburst : m_arburst;
          if (m_awcache !== m_arcache) cache_bad++;
        end
        if (wr ? m_awready : m_arready) begin a_hs_now = 1; aw_cyc = cyc; end else avc++;
      end
      if (m_wvalid && m_wready) begin
        if (!(cpu_wvalid && cpu_wready) || m_wdata !== dq[xin]) data_bad++;
        if (m_wlast !== (xin == int'(len))) wlast_bad++;
        if (xin == int'(len)) wl_cyc = cyc;
        if (!a_done && !a_hs_now) w_lead = 1;
        xin++; n_beats++;
      end else if (cpu_wvalid && cpu_wready) data_bad++;
      exp_rr = !wr && a_done && cpu_rready;
      exp_br = wr && a_done && (xin > int'(len)) && !(m_wvalid && m_wready);
      if (m_rready !== exp_rr || m_bready !== exp_br) mirror_bad++;
      if (m_rvalid && m_rready) begin
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== dq[xout] || cpu_rlast !== m_rlast) data_bad++;
        if (m_rlast) last_now = 1;
        xout++; n_beats++;
      end
      exp_done = wr ? (m_bvalid && m_bready) : last_now;
      if (cpu_done !== exp_done) done_bad++;
      if (cpu_done) begin
        done_cnt++;
`ifdef MMU_BRIDGE_ERR_EN
        err_at_done = int'(cpu_err);
`endif
      end
      if (exp_done) fin = 1;
      if (a_hs_now) a_done = 1;
      cyc++;
      @(posedge clk); #1;
    end
    same_cyc = int'(aw_cyc == wl_cyc);
    idle_inputs(); #1;
    rdy_next = int'(cpu_req_ready === 1'b1 && cpu_done === 1'b0);
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1;
    #12;
    if ({m_arvalid, m_awvalid, m_wvalid, m_wlast, cpu_wready, cpu_rvalid, cpu_done, m_bready, m_rready} !== 9'b0) begin
      errors++; $display("FAIL reset_outs got %b want 0", {m_arvalid, m_awvalid, m_wvalid, m_wlast, cpu_wready, cpu_rvalid, cpu_done, m_bready, m_rready});
    end
    checks++;
    @(posedge clk); #1; reset = 0; @(posedge clk); #1;
    if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cpu_req_ready); end
    checks++;
  endtask

  task automatic test_read_kseg0();
    stall_pct = 0; addr_delay = 2; err_beat = -1;
    do_txn(1'b0, 32'h8000_1000, 8'd3, 3'd2);
    if (cap_addr !== 32'h0000_1000 || cap_addr !== ref_addr(32'h8000_1000)) begin errors++; $display("FAIL rd_araddr got %h want 00001000", cap_addr); end
    checks++;
    if ({cap_len, cap_cache, cap_burst, cap_size} !== {8'd3, 4'hF, 2'b01, 3'd2}) begin
      errors++; $display("FAIL rd_ctrl got len=%0d cache=%h burst=%b size=%0d", cap_len, cap_cache, cap_burst, cap_size); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL rd_latency got %0d want 1", lat); end
    checks++;
    if (n_beats !== 4 || done_cnt !== 1 || done_bad !== 0 || data_bad !== 0 || timeout !== 0) begin
      errors++; $display("FAIL rd_beats got beats=%0d done=%0d dbad=%0d data=%0d to=%0d want 4,1,0,0,0", n_beats, done_cnt, done_bad, data_bad, timeout); end
    checks++;
  endtask

  task automatic test_write_kseg1();
    stall_pct = 0; addr_delay = 4;
    do_txn(1'b1, 32'hBFC0_0040, 8'd0, 3'd2);
    if (cap_addr !== 32'h1FC0_0040 || cap_cache !== 4'h0 || cache_bad !== 0) begin
      errors++; $display("FAIL wr_kseg1 got addr=%h cache=%h want 1fc00040,0", cap_addr, cap_cache); end
    checks++;
    if (w_lead !== 1 || n_beats !== 1 || wlast_bad !== 0) begin
      errors++; $display("FAIL wr_wlead got lead=%0d beats=%0d wlast_bad=%0d want 1,1,0", w_lead, n_beats, wlast_bad); end
    checks++;
    if (done_cnt !== 1 || done_bad !== 0 || mirror_bad !== 0 || timeout !== 0) begin
      errors++; $display("FAIL wr_done got done=%0d dbad=%0d mbad=%0d to=%0d want 1,0,0,0", done_cnt, done_bad, mirror_bad, timeout); end
    checks++;
  endtask

  task automatic test_write_len7();
    stall_pct = 0; addr_delay = 7;
    do_txn(1'b1, 32'h0040_0000, 8'd7, 3'd2);
    if (same_cyc !== 1 || n_beats !== 8 || wlast_bad !== 0 || done_cnt !== 1 || done_bad !== 0 || data_bad !== 0) begin
      errors++; $display("FAIL wr8_same got same=%0d beats=%0d wl=%0d done=%0d dbad=%0d data=%0d", same_cyc, n_beats, wlast_bad, done_cnt, done_bad, data_bad); end
    checks++;
    stall_pct = 40; addr_delay = 1;
    do_txn(1'b1, 32'hC123_4560, 8'd7, 3'd2);
    if (n_beats !== 8 || wlast_bad !== 0 || done_cnt !== 1 || done_bad !== 0 || data_bad !== 0 || timeout !== 0) begin
      errors++; $display("FAIL wr8_stall got beats=%0d wl=%0d done=%0d dbad=%0d data=%0d to=%0d", n_beats, wlast_bad, done_cnt, done_bad, data_bad, timeout); end
    checks++;
  endtask

  task automatic test_back_to_back();
    stall_pct = 50; addr_delay = 0;
    do_txn(1'b0, 32'h0000_2000, 8'd1, 3'd2);
    if (mirror_bad !== 0 || n_beats !== 2 || data_bad !== 0 || done_cnt !== 1 || rdy_next !== 1) begin
      errors++; $display("FAIL rd_toggle got mbad=%0d beats=%0d data=%0d done=%0d rdy=%0d", mirror_bad, n_beats, data_bad, done_cnt, rdy_next); end
    checks++;
    stall_pct = 0;
    do_txn(1'b0, 32'h9000_0000, 8'd0, 3'd2);
    if (acc_cyc !== 0 || cap_addr !== 32'h1000_0000 || done_cnt !== 1) begin
      errors++; $display("FAIL b2b_accept got acc=%0d addr=%h done=%0d want 0,10000000,1", acc_cyc, cap_addr, done_cnt); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int bad;
    idle_inputs();
    cpu_req_valid = 1; cpu_req_addr = 32'hC000_0100; cpu_req_len = 8'd3; cpu_req_size = 3'd2; m_arready = 1; cpu_rready = 1;
    @(posedge clk); #1; cpu_req_valid = 0;
    @(posedge clk); #1; m_rvalid = 1; m_rdata = 32'h1111_1111;
    @(posedge clk); #1; m_rdata = 32'h2222_2222; #1;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h2222_2222) begin errors++; $display("FAIL rst_mid_pre got rvalid=%b data=%h", cpu_rvalid, cpu_rdata); end
    checks++;
    reset = 1; #1;
    if ({m_arvalid, m_awvalid, m_wvalid, cpu_rvalid, m_rready, m_bready, cpu_done} !== 7'b0) begin
      errors++; $display("FAIL rst_mid_async got %b want 0", {m_arvalid, m_awvalid, m_wvalid, cpu_rvalid, m_rready, m_bready, cpu_done}); end
    checks++;
    @(posedge clk); #1; reset = 0; idle_inputs();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (cpu_req_ready !== 1'b1 || cpu_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    if (bad !== 0) begin errors++; $display("FAIL rst_mid_after got %0d bad cycles want 0", bad); end
    checks++;
  endtask

  task automatic test_random();
    logic wr; logic [31:0] a; logic [7:0] len;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(1)); a = $urandom; len = 8'($urandom_range(15));
      stall_pct = $urandom_range(40); addr_delay = $urandom_range(3);
      do_txn(wr, a, len, 3'($urandom_range(2)));
      if (cap_addr !== ref_addr(a) || cap_cache !== ref_cache(a) || cap_len !== len || cache_bad !== 0 || lat !== 1) begin
        errors++; $display("FAIL rnd_addr[%0d] got addr=%h cache=%h len=%0d lat=%0d want %h %h %0d 1", n, cap_addr, cap_cache, cap_len, lat, ref_addr(a), ref_cache(a), len); end
      checks++;
      if (n_beats !== int'(len) + 1 || done_cnt !== 1 || done_bad !== 0 || data_bad !== 0 || wlast_bad !== 0 || mirror_bad !== 0 || timeout !== 0) begin
        errors++; $display("FAIL rnd_xfer[%0d] wr=%b got beats=%0d done=%0d dbad=%0d data=%0d wl=%0d mbad=%0d to=%0d want beats=%0d", n, wr, n_beats, done_cnt, done_bad, data_bad, wlast_bad, mirror_bad, timeout, int'(len) + 1); end
      checks++;
    end
  endtask

`ifdef MMU_BRIDGE_ERR_EN
  task automatic test_err();
    stall_pct = 0; addr_delay = 0; err_beat = 1; bresp_val = 2'b00;
    do_txn(1'b0, 32'h8000_3000, 8'd3, 3'd2);
    if (err_at_done !== 1 || done_cnt !== 1) begin errors++; $display("FAIL err_rresp got err=%0d done=%0d want 1,1", err_at_done, done_cnt); end
    checks++;
    err_beat = -1;
    do_txn(1'b1, 32'h0000_3000, 8'd1, 3'd2);
    if (err_at_done !== 0 || done_cnt !== 1) begin errors++; $display("FAIL err_clean got err=%0d done=%0d want 0,1", err_at_done, done_cnt); end
    checks++;
    bresp_val = 2'b11;
    do_txn(1'b1, 32'h0000_3000, 8'd0, 3'd2);
    if (err_at_done !== 1) begin errors++; $display("FAIL err_bresp got %0d want 1", err_at_done); end
    checks++;
    bresp_val = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_read_kseg0();
    test_write_kseg1();
    test_write_len7();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MMU_BRIDGE_ERR_EN
    test_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
